program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/prog_seq_pkg.sv | 38 +++
 rtl/watchdog_timer.sv | 47 ++++
 rtl/program_sequencer.sv | 152 +++++++++++++++
 tb/tb_program_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_seq_pkg
//  Description : Shared opcode constants, opcode field range and sequencer
//                state encoding for program_sequencer and its testbench.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_seq_pkg;

    // Opcode field position inside a 16-bit program word
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;

    // Opcodes the sequencer itself interprets
    localparam logic [3:0] MVI_OP  = 4'h1;
    localparam logic [3:0] HALT_OP = 4'hF;

    // Sequencer state encoding
    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_IMM_FETCH = 4'd3;
    localparam logic [3:0] S_IMM_LOAD  = 4'd4;
    localparam logic [3:0] S_ISSUE     = 4'd5;
    localparam logic [3:0] S_WAIT_DONE = 4'd6;
    localparam logic [3:0] S_HALTED    = 4'd7;
    localparam logic [3:0] S_FAULT     = 4'd8;

    // Extract the opcode field from a program word
    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[OP_HI:OP_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/watchdog_timer.sv
`default_nettype none
// ============================================================================
//  Module      : watchdog_timer
//  Description : Counts enabled cycles since the last clear and flags
//                expiry on the WDT_CYCLES-th enabled cycle. The count
//                saturates so expiry stays asserted while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module watchdog_timer #(
    parameter int WDT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             CNT_W  = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise advance while enabled up to the last value
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != C_LAST)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer
//  Description : Fetches words from a synchronous program ROM, issues them to
//                a processor with a one-cycle run strobe, supplies the mvi
//                immediate while waiting, and retires on the done pulse.
//                A watchdog faults the sequencer if done never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer
    import prog_seq_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int WDT_CYCLES = 64
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       DIN,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       instr_count
);

    localparam logic [ADDR_W-1:0] C_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [15:0]       ir_q,    ir_d;
    logic [15:0]       imm_q,   imm_d;
    logic [15:0]       din_q,   din_d;
    logic [15:0]       count_q, count_d;
    logic              wdt_clear;
    logic              wdt_enable;
    logic              wdt_expired;

    assign wdt_clear  = (state_q == S_ISSUE);
    assign wdt_enable = (state_q == S_WAIT_DONE);

    watchdog_timer #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk_i     (clk_50MHz),
        .rst_i     (reset),
        .clear_i   (wdt_clear),
        .enable_i  (wdt_enable),
        .expired_o (wdt_expired)
    );

    // Sequencer next-state logic; DIN is loaded on entry to ISSUE and WAIT_DONE
    // so the processor sees a registered word in both states.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        din_d   = din_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode_of(rom_data) == HALT_OP) begin
                    state_d = S_HALTED;
                end else begin
                    ir_d = rom_data;
                    pc_d = pc_q + C_PC_ONE;
                    if (opcode_of(rom_data) == MVI_OP) begin
                        state_d = S_IMM_FETCH;
                    end else begin
                        din_d   = rom_data;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_IMM_FETCH: begin
                state_d = S_IMM_LOAD;
            end
            S_IMM_LOAD: begin
                imm_d   = rom_data;
                pc_d    = pc_q + C_PC_ONE;
                din_d   = ir_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                din_d   = (opcode_of(ir_q) == MVI_OP) ? imm_q : ir_q;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // done on the expiry cycle still retires the instruction
                if (done) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    state_d = S_FETCH;
                end else if (wdt_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            din_q   <= din_d;
            count_q <= count_d;
        end
    end

    assign rom_addr    = pc_q;
    assign DIN         = din_q;
    assign instr_count = count_q;
    assign run         = (state_q == S_ISSUE);
    assign busy        = (state_q == S_FETCH)     || (state_q == S_DECODE)   ||
                         (state_q == S_IMM_FETCH) || (state_q == S_IMM_LOAD) ||
                         (state_q == S_ISSUE)     || (state_q == S_WAIT_DONE);
    assign halted      = (state_q == S_HALTED);
    assign fault       = (state_q == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_sequencer
//  Description : Directed self-checking bench for program_sequencer; a second
//                instance with ADDR_W=2 exercises program-counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] DIN;
    logic        run, busy, halted, fault;
    logic [15:0] instr_count;
    logic [15:0] rom [0:255];

    logic        start2 = 1'b0;
    logic        done2 = 1'b0;
    logic [1:0]  rom_addr2;
    logic [15:0] rom_data2;
    logic [15:0] DIN2;
    logic        run2, busy2, halted2, fault2;
    logic [15:0] instr_count2;
    logic [15:0] rom2 [0:3];

    int checks = 0;
    int errors = 0;
    int run_cnt = 0;

    // 50 MHz clock
    always #10 clk = ~clk;

    // Synchronous program ROMs
    always @(posedge clk) rom_data  <= rom[rom_addr];
    always @(posedge clk) rom_data2 <= rom2[rom_addr2];

    // Count issue strobes of the main instance
    always @(posedge clk) if (run === 1'b1) run_cnt <= run_cnt + 1;

    program_sequencer #(.ADDR_W(8), .WDT_CYCLES(64)) dut (
        .clk_50MHz(clk), .reset(reset), .start(start), .rom_addr(rom_addr),
        .rom_data(rom_data), .DIN(DIN), .run(run), .done(done), .busy(busy),
        .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    program_sequencer #(.ADDR_W(2), .WDT_CYCLES(64)) dut2 (
        .clk_50MHz(clk), .reset(reset), .start(start2), .rom_addr(rom_addr2),
        .rom_data(rom_data2), .DIN(DIN2), .run(run2), .done(done2), .busy(busy2),
        .halted(halted2), .fault(fault2), .instr_count(instr_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; done = 1'b1;
        tick(); tick();
        reset = 1'b0; start = 1'b0; done = 1'b0;
        checks++; if ({run, busy, halted, fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {run, busy, halted, fault}); end
        checks++; if (DIN !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h expected 0000", DIN); end
        checks++; if (instr_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", instr_count); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", rom_addr); end
    endtask

    task automatic test_single();
        int rc;
        rom[0] = 16'h0123; rom[1] = 16'hF000;
        rc = run_cnt;
        start = 1'b1; tick(); start = 1'b0;                 // cycle 1: FETCH
        checks++; if (busy !== 1'b1 || rom_addr !== 8'h00) begin errors++; $display("FAIL single_fetch: got busy=%b addr=%h expected busy=1 addr=00", busy, rom_addr); end
        tick();                                             // cycle 2: DECODE
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL single_early_run: got %b expected 0", run); end
        tick();                                             // cycle 3: ISSUE
        checks++; if (run !== 1'b1 || DIN !== 16'h0123) begin errors++; $display("FAIL single_issue: got run=%b DIN=%h expected run=1 DIN=0123", run, DIN); end
        tick();                                             // cycle 4: WAIT_DONE
        checks++; if (run !== 1'b0 || DIN !== 16'h0123) begin errors++; $display("FAIL single_wait: got run=%b DIN=%h expected run=0 DIN=0123", run, DIN); end
        tick(); done = 1'b1; tick(); done = 1'b0;           // cycle 6: FETCH
        checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", instr_count); end
        tick(); tick();                                     // cycle 8: HALTED
        checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_halt: got halted=%b busy=%b expected 1 0", halted, busy); end
        checks++; if (rom_addr !== 8'h01) begin errors++; $display("FAIL single_pc: got %h expected 01", rom_addr); end
        checks++; if (run_cnt - rc !== 1) begin errors++; $display("FAIL single_runs: got %0d expected 1", run_cnt - rc); end
        checks++; if (DIN !== 16'h0123) begin errors++; $display("FAIL single_din_hold: got %h expected 0123", DIN); end
    endtask

    task automatic test_mvi();
        rom[0] = 16'h1200; rom[1] = 16'h00AB; rom[2] = 16'hF000;
        start = 1'b1; tick(); start = 1'b0;                 // cycle 1 (restart from HALTED)
        checks++; if (instr_count !== 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL mvi_restart: got count=%0d busy=%b expected 0 1", instr_count, busy); end
        tick(); tick();                                     // cycle 3: IMM_FETCH
        checks++; if (run !== 1'b0 || rom_addr !== 8'h01) begin errors++; $display("FAIL mvi_immfetch: got run=%b addr=%h expected 0 01", run, rom_addr); end
        tick(); tick();                                     // cycle 5: ISSUE
        checks++; if (run !== 1'b1 || DIN !== 16'h1200) begin errors++; $display("FAIL mvi_issue: got run=%b DIN=%h expected 1 1200", run, DIN); end
        tick();                                             // cycle 6: WAIT_DONE
        checks++; if (run !== 1'b0 || DIN !== 16'h00AB) begin errors++; $display("FAIL mvi_imm: got run=%b DIN=%h expected 0 00AB", run, DIN); end
        tick();
        checks++; if (DIN !== 16'h00AB) begin errors++; $display("FAIL mvi_imm_hold: got %h expected 00AB", DIN); end
        done = 1'b1; tick(); done = 1'b0;                   // cycle 8: FETCH
        checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL mvi_count: got %0d expected 1", instr_count); end
        tick(); tick();                                     // cycle 10: HALTED
        checks++; if (halted !== 1'b1 || rom_addr !== 8'h02) begin errors++; $display("FAIL mvi_halt: got halted=%b addr=%h expected 1 02", halted, rom_addr); end
    endtask

    task automatic test_watchdog();
        reset = 1'b1; tick(); reset = 1'b0;
        rom[0] = 16'h0123;
        start = 1'b1; tick(); start = 1'b0;                 // cycle 1
        tick(); tick(); tick();                             // cycle 4: first WAIT_DONE cycle
        for (int i = 0; i < 63; i++) begin
            start = (i == 5);
            tick();
        end
        start = 1'b0;                                       // cycle 67
        checks++; if (fault !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wdt_early: got fault=%b busy=%b expected 0 1", fault, busy); end
        tick();                                             // cycle 68
        checks++; if (fault !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wdt_fault: got fault=%b busy=%b expected 1 0", fault, busy); end
        start = 1'b1; tick(); start = 1'b0; tick();
        checks++; if (fault !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wdt_sticky: got fault=%b busy=%b expected 1 0", fault, busy); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if ({run, busy, halted, fault} !== 4'b0000 || DIN !== 16'h0 || rom_addr !== 8'h0) begin errors++; $display("FAIL wdt_reset: got flags=%b DIN=%h addr=%h expected 0000 0000 00", {run, busy, halted, fault}, DIN, rom_addr); end
    endtask

    task automatic test_wdt_boundary();
        rom[0] = 16'h0123; rom[1] = 16'hF000;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();                             // cycle 4
        for (int i = 0; i < 63; i++) tick();                // cycle 67: expiry cycle
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (fault !== 1'b0 || busy !== 1'b1 || instr_count !== 16'd1) begin errors++; $display("FAIL wdt_done_wins: got fault=%b busy=%b count=%0d expected 0 1 1", fault, busy, instr_count); end
        tick(); tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wdt_boundary_halt: got %b expected 1", halted); end
    endtask

    task automatic test_reset_mid();
        rom[0] = 16'h0123;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();                                     // cycle 3: ISSUE
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL rmid_issue: got %b expected 1", run); end
        tick();                                             // cycle 4
        reset = 1'b1; done = 1'b1; tick(); reset = 1'b0; done = 1'b0;
        checks++; if ({run, busy, halted, fault} !== 4'b0000 || DIN !== 16'h0 || instr_count !== 16'h0 || rom_addr !== 8'h0) begin errors++; $display("FAIL rmid_reset: got flags=%b DIN=%h count=%0d addr=%h expected 0000 0000 0 00", {run, busy, halted, fault}, DIN, instr_count, rom_addr); end
        done = 1'b1; tick(); done = 1'b0; tick();
        checks++; if (instr_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_stray_done: got count=%0d busy=%b expected 0 0", instr_count, busy); end
    endtask

    task automatic test_ignored();
        rom[0] = 16'h0123; rom[1] = 16'hF000;
        start = 1'b1; tick(); start = 1'b0;                 // cycle 1: FETCH
        done = 1'b1; tick(); done = 1'b0;                   // cycle 2: DECODE
        checks++; if (instr_count !== 16'd0 || rom_addr !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL ign_done_fetch: got count=%0d addr=%h busy=%b expected 0 00 1", instr_count, rom_addr, busy); end
        tick();                                             // cycle 3: ISSUE
        tick();                                             // cycle 4: WAIT_DONE
        start = 1'b1; tick(); start = 1'b0;                 // cycle 5
        checks++; if (run !== 1'b0 || busy !== 1'b1 || rom_addr !== 8'h01 || instr_count !== 16'd0) begin errors++; $display("FAIL ign_start_wait: got run=%b busy=%b addr=%h count=%0d expected 0 1 01 0", run, busy, rom_addr, instr_count); end
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL ign_retire: got %0d expected 1", instr_count); end
        tick(); tick();
    endtask

    task automatic test_wrap();
        logic [1:0] exp_addr;
        int k;
        start2 = 1'b1; tick(); start2 = 1'b0;               // FETCH at pc 0
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (run2 !== 1'b1 && k < 10) begin
                tick();
                k++;
            end
            exp_addr = 2'(i + 1);
            checks++; if (k !== 2) begin errors++; $display("FAIL wrap_latency[%0d]: got %0d cycles expected 2", i, k); end
            checks++; if (rom_addr2 !== exp_addr) begin errors++; $display("FAIL wrap_pc[%0d]: got %0d expected %0d", i, rom_addr2, exp_addr); end
            tick();                                         // WAIT_DONE
            done2 = 1'b1; tick(); done2 = 1'b0;
        end
        checks++; if (instr_count2 !== 16'd5 || busy2 !== 1'b1) begin errors++; $display("FAIL wrap_count: got count=%0d busy=%b expected 5 1", instr_count2, busy2); end
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    // Test sequence
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
        test_reset();
        test_single();
        test_mvi();
        test_watchdog();
        test_wdt_boundary();
        test_reset_mid();
        test_ignored();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
